// File: rtl/mem_arbiter_pkg.sv
// Shared types for the imem/dmem arbiter: FSM state encoding, also used as the
// combinational grant (ARB_IDLE meaning "nothing granted").
package rv32i_types;

  typedef enum logic [1:0] {
    ARB_IDLE    = 2'd0,
    ARB_SERVE_D = 2'd1,
    ARB_SERVE_I = 2'd2
  } arb_state_t;

endpackage

// File: rtl/mem_arbiter_req_latch.sv
// One outstanding request per port: pending flag plus the registered address,
// masks and store data, loaded on a capture pulse and dropped on clear.
module arb_req_latch #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  localparam int MW = DATA_WIDTH / 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  capture,
  input  logic                  clear,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  input  logic [MW-1:0]         req_rmask,
  input  logic [MW-1:0]         req_wmask,
  input  logic [DATA_WIDTH-1:0] req_wdata,
  output logic                  pending,
  output logic [ADDR_WIDTH-1:0] addr,
  output logic [MW-1:0]         rmask,
  output logic [MW-1:0]         wmask,
  output logic [DATA_WIDTH-1:0] wdata
);

  // A pulse while already pending is a protocol error and is ignored; clear
  // only happens while pending, so it never collides with an accepted capture.
  always_ff @(posedge clk) begin
    if (rst) begin
      pending <= 1'b0;
      addr    <= '0;
      rmask   <= '0;
      wmask   <= '0;
      wdata   <= '0;
    end else if (capture && !pending) begin
      pending <= 1'b1;
      addr    <= req_addr;
      rmask   <= req_rmask;
      wmask   <= req_wmask;
      wdata   <= req_wdata;
    end else if (clear) begin
      pending <= 1'b0;
    end
  end

endmodule

// File: rtl/mem_arbiter.sv
// Serialises latched imem/dmem requests onto one backing memory port, dmem
// first, non-preemptive, and returns registered one-cycle responses.
module mem_arbiter
  import rv32i_types::*;
#(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  localparam int MW = DATA_WIDTH / 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [ADDR_WIDTH-1:0] imem_addr,
  input  logic [MW-1:0]         imem_rmask,
  output logic [DATA_WIDTH-1:0] imem_rdata,
  output logic                  imem_resp,
  input  logic [ADDR_WIDTH-1:0] dmem_addr,
  input  logic [MW-1:0]         dmem_rmask,
  input  logic [MW-1:0]         dmem_wmask,
  input  logic [DATA_WIDTH-1:0] dmem_wdata,
  output logic [DATA_WIDTH-1:0] dmem_rdata,
  output logic                  dmem_resp,
  output logic [ADDR_WIDTH-1:0] bmem_addr,
  output logic                  bmem_read,
  output logic                  bmem_write,
  output logic [MW-1:0]         bmem_wmask,
  output logic [DATA_WIDTH-1:0] bmem_wdata,
  input  logic [DATA_WIDTH-1:0] bmem_rdata,
  input  logic                  bmem_resp
);

  arb_state_t state, state_next, grant;

  logic                  i_pending, d_pending;
  logic [ADDR_WIDTH-1:0] i_addr, d_addr;
  logic [MW-1:0]         i_rmask, i_wmask, d_rmask, d_wmask;
  logic [DATA_WIDTH-1:0] i_wdata, d_wdata;
  logic                  i_req, d_req, i_clear, d_clear;

  assign i_req   = |imem_rmask;
  assign d_req   = |dmem_rmask || |dmem_wmask;
  assign i_clear = (grant == ARB_SERVE_I) && bmem_resp;
  assign d_clear = (grant == ARB_SERVE_D) && bmem_resp;

  arb_req_latch #(.ADDR_WIDTH(ADDR_WIDTH), .DATA_WIDTH(DATA_WIDTH)) u_imem_latch (
    .clk       (clk),
    .rst       (rst),
    .capture   (i_req),
    .clear     (i_clear),
    .req_addr  (imem_addr),
    .req_rmask (imem_rmask),
    .req_wmask ('0),
    .req_wdata ('0),
    .pending   (i_pending),
    .addr      (i_addr),
    .rmask     (i_rmask),
    .wmask     (i_wmask),
    .wdata     (i_wdata)
  );

  arb_req_latch #(.ADDR_WIDTH(ADDR_WIDTH), .DATA_WIDTH(DATA_WIDTH)) u_dmem_latch (
    .clk       (clk),
    .rst       (rst),
    .capture   (d_req),
    .clear     (d_clear),
    .req_addr  (dmem_addr),
    .req_rmask (dmem_rmask),
    .req_wmask (dmem_wmask),
    .req_wdata (dmem_wdata),
    .pending   (d_pending),
    .addr      (d_addr),
    .rmask     (d_rmask),
    .wmask     (d_wmask),
    .wdata     (d_wdata)
  );

  always_ff @(posedge clk) begin
    if (rst) state <= ARB_IDLE;
    else     state <= state_next;
  end

  // From IDLE the grant is decided straight from the pending flags so the
  // backing strobe rises the cycle after the request pulse.
  always_comb begin
    grant = state;
    if (state == ARB_IDLE) begin
      if (d_pending)      grant = ARB_SERVE_D;
      else if (i_pending) grant = ARB_SERVE_I;
    end
  end

  always_comb begin
    state_next = grant;
    if (bmem_resp) begin
      case (grant)
        ARB_SERVE_D: state_next = i_pending ? ARB_SERVE_I : ARB_IDLE;
        ARB_SERVE_I: state_next = d_pending ? ARB_SERVE_D : ARB_IDLE;
        default:     state_next = ARB_IDLE;
      endcase
    end
  end

  // A read mask takes precedence so read and write are never high together.
  always_comb begin
    bmem_addr  = '0;
    bmem_read  = 1'b0;
    bmem_write = 1'b0;
    bmem_wmask = '0;
    bmem_wdata = '0;
    case (grant)
      ARB_SERVE_D: begin
        bmem_addr  = d_addr;
        bmem_read  = |d_rmask;
        bmem_write = !(|d_rmask) && |d_wmask;
      end
      ARB_SERVE_I: begin
        bmem_addr  = i_addr;
        bmem_read  = |i_rmask;
        bmem_write = !(|i_rmask) && |i_wmask;
      end
      default: ;
    endcase
    if (bmem_write) begin
      bmem_wmask = (grant == ARB_SERVE_D) ? d_wmask : i_wmask;
      bmem_wdata = (grant == ARB_SERVE_D) ? d_wdata : i_wdata;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      imem_resp  <= 1'b0;
      imem_rdata <= '0;
      dmem_resp  <= 1'b0;
      dmem_rdata <= '0;
    end else begin
      imem_resp  <= i_clear;
      imem_rdata <= (i_clear && |i_rmask) ? bmem_rdata : '0;
      dmem_resp  <= d_clear;
      dmem_rdata <= (d_clear && |d_rmask) ? bmem_rdata : '0;
    end
  end

  a_imem_one_outstanding: assert property (@(posedge clk) disable iff (rst)
    !(i_req && i_pending));
  a_dmem_one_outstanding: assert property (@(posedge clk) disable iff (rst)
    !(d_req && d_pending));
  a_dmem_not_load_and_store: assert property (@(posedge clk) disable iff (rst)
    !(|dmem_rmask && |dmem_wmask));

endmodule
